// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between NREQ requesters.
// Each job takes one grant cycle and one EXEC cycle, then a registered response is held until accepted.
module alu_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_src1,
    input  logic [32*NREQ-1:0]   req_src2,
    input  logic [3*NREQ-1:0]    req_op,
    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    output logic [2:0]           alu_op,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  lat_id;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] gnt_oh;
    logic            gnt_any;
    logic [31:0]     sel_src1, sel_src2;
    logic [2:0]      sel_op;
    logic            grant;

    // Search rr_ptr, rr_ptr+1, ... (mod NREQ) for the first valid requester.
    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so the search reads its own partial results and no latch is inferred.
    always_comb begin
        int pos;
        gnt_oh  = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_any && pos == i && req_valid[i]) begin
                    gnt_oh[i] = 1'b1;
                    gnt_id    = IDW'(i);
                    gnt_any   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        sel_op   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_src1 = req_src1[32*i +: 32];
                sel_src2 = req_src2[32*i +: 32];
                sel_op   = req_op[3*i +: 3];
            end
        end
    end

    // rst_n gates req_ready so no handshake is offered while reset is held.
    assign req_ready = (state == IDLE && rst_n) ? gnt_oh : '0;
    assign grant     = (state == IDLE) && gnt_any;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any)   state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: these are a handful of flops, not a memory, so all of them reset;
    // an aborted job leaves no stale operands or response behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            lat_id     <= '0;
            alu_src1   <= '0;
            alu_src2   <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            // Operand registers drive the ALU directly and hold between jobs.
            if (grant) begin
                alu_src1 <= sel_src1;
                alu_src2 <= sel_src2;
                alu_op   <= sel_op;
                lat_id   <= gnt_id;
                rr_ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_id     <= lat_id;
                rsp_valid  <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with NREQ=2; a behavioural ALU closes the loop.
module tb_alu_rr_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_BAD = 3'b111;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_src1;
    logic [32*NREQ-1:0]  req_src2;
    logic [3*NREQ-1:0]   req_op;
    logic [31:0]         alu_src1, alu_src2;
    logic [2:0]          alu_op;
    logic [31:0]         alu_result;
    logic                alu_zero;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_result;
    logic                rsp_zero;
    logic                busy;

    int n_vec  = 0;
    int n_miss = 0;

    alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_op     (req_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    // Behavioural external ALU.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_src1 + alu_src2;
            OP_SUB:  alu_result = alu_src1 - alu_src2;
            OP_AND:  alu_result = alu_src1 & alu_src2;
            OP_OR:   alu_result = alu_src1 | alu_src2;
            OP_XOR:  alu_result = alu_src1 ^ alu_src2;
            default: alu_result = 32'h0;
        endcase
    end
    assign alu_zero = (alu_result == 32'h0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_src1[32*idx +: 32] = a;
        req_src2[32*idx +: 32] = b;
        req_op[3*idx +: 3]     = op;
    endtask

    // Entered at a negedge with the DUT idle and rsp_ready high; leaves at a negedge in IDLE.
    task automatic run_single(input string tag, input int idx, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res, input logic exp_zero);
        set_req(idx, op, a, b);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
        @(negedge clk);
        req_valid = '0;
        #1;
        check({tag, "_exec_busy"}, 32'(busy), 32'd1);
        check({tag, "_exec_rvalid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_alu_src1"}, alu_src1, a);
        check({tag, "_alu_src2"}, alu_src2, b);
        check({tag, "_alu_op"}, 32'(alu_op), 32'(op));
        @(negedge clk);
        #1;
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(idx));
        check({tag, "_rsp_result"}, rsp_result, exp_res);
        check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
        @(negedge clk);
        #1;
        check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int        n_gnt;
        int        last_cyc;
        int        exp_q[$];
        int        eid;

        rst_n     = 1'b0;
        req_valid = '0;
        req_src1  = '0;
        req_src2  = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_alu_src1", alu_src1, 32'd0);
        check("rst_alu_src2", alu_src2, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_single("single", 0, OP_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0);
        run_single("sub_zero", 1, OP_SUB, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1);
        run_single("add_wrap", 1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);

        // Round-robin: both requesters continuously valid, rr_ptr is 0 here.
        set_req(0, OP_ADD, 32'd10, 32'd20);
        set_req(1, OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
        req_valid = 2'b11;
        n_gnt     = 0;
        last_cyc  = 0;
        for (int cyc = 0; cyc < 60 && (n_gnt < 6 || exp_q.size() > 0); cyc++) begin
            if (n_gnt >= 6) req_valid = '0;
            #1;
            if (rsp_valid) begin
                if (exp_q.size() > 0) begin
                    eid = exp_q.pop_front();
                    check("rr_rsp_id", 32'(rsp_id), 32'(eid));
                    check("rr_rsp_result", rsp_result, (eid == 0) ? 32'd30 : 32'h0000_FF00);
                end else begin
                    check("rr_spurious_rsp", 32'(rsp_valid), 32'd0);
                end
            end
            if (req_ready != '0) begin
                eid = n_gnt % 2;
                check("rr_grant", 32'(req_ready), 32'(1 << eid));
                if (n_gnt > 0) check("rr_gap", 32'(cyc - last_cyc), 32'd3);
                exp_q.push_back(eid);
                last_cyc = cyc;
                n_gnt++;
            end
            @(negedge clk);
        end
        check("rr_grants", 32'(n_gnt), 32'd6);
        check("rr_pending", 32'(exp_q.size()), 32'd0);
        req_valid = '0;
        @(negedge clk);

        // Backpressure: response held for 5 cycles while requester 1 waits.
        rsp_ready = 1'b0;
        set_req(0, OP_OR, 32'h0000_00F0, 32'h0000_0F00);
        set_req(1, OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        req_valid = 2'b01;
        #1;
        check("bp_grant0", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_result", rsp_result, 32'h0000_0FF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
            check("bp_hold_result", rsp_result, 32'h0000_0FF0);
            check("bp_hold_zero", 32'(rsp_zero), 32'd0);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_alu_src1", alu_src1, 32'h0000_00F0);
            check("bp_hold_alu_src2", alu_src2, 32'h0000_0F00);
            check("bp_hold_alu_op", 32'(alu_op), 32'(OP_OR));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_grant1", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("bp_r1_id", 32'(rsp_id), 32'd1);
        check("bp_r1_result", rsp_result, 32'h0F00_0F00);
        @(negedge clk);

        run_single("illegal", 0, OP_BAD, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b1);
        run_single("post_illegal", 1, OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0);

        // Reset during EXEC: rr_ptr becomes 1 after this grant, reset must restore 0.
        set_req(0, OP_ADD, 32'h0000_0100, 32'h0000_0023);
        set_req(1, OP_ADD, 32'h0000_0200, 32'h0000_0045);
        req_valid = 2'b11;
        #1;
        check("mr_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        #1;
        check("mr_in_exec", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_req_ready", 32'(req_ready), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_alu_src1", alu_src1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_regrant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("mr_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("mr_rsp_id", 32'(rsp_id), 32'd0);
        check("mr_rsp_result", rsp_result, 32'h0000_0123);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
